axi_lite_slave_mem: RTL
=======================

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of AWADDR/ARADDR.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-003 SHALL have parameter MEM_BYTES, default 4096, local RAM size in bytes (power of two).
REQ-004 SHALL have ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  ADDR_W  write byte address.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte-lane enables.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  write response.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  ADDR_W  read byte address.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response.

Function
REQ-005 SHALL implement an AXI4-Lite responder on a byte RAM of MEM_BYTES; word index = ADDR[log2(MEM_BYTES)-1:2]; ADDR[1:0] ignored.
REQ-006 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP; all outputs registered.
REQ-007 AWREADY=1 in W_IDLE and W_HAVE_DATA only; WREADY=1 in W_IDLE and W_HAVE_ADDR only; handshake = VALID&&READY at rising edge.
REQ-008 AW alone from W_IDLE -> W_HAVE_ADDR (address latched); W alone -> W_HAVE_DATA (data/strobe latched); both same edge, or the second one later, -> W_RESP.
REQ-009 On the edge entering W_RESP, RAM SHALL write byte lane i iff WSTRB[i]; BVALID rises that edge; WSTRB=0 changes nothing and responds OKAY.
REQ-010 BVALID and BRESP SHALL hold stable until BREADY; on the BVALID&&BREADY edge -> W_IDLE; minimum write cycle 3 clocks (accept, respond, ready again).
REQ-011 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_VALID (ARREADY=0); AR handshake latches RAM word into RDATA and sets RVALID=1 on the same edge.
REQ-012 RVALID, RDATA and RRESP SHALL hold stable until RREADY; on the RVALID&&RREADY edge -> R_IDLE.
REQ-013 One outstanding transaction per direction; read and write FSMs independent and concurrent.
REQ-014 Read and write committing the same word on the same edge: read SHALL return pre-write data.
REQ-015 BRESP/RRESP SHALL be 2'b00 (OKAY) unless REQ-020 applies.

Reset
REQ-016 ARESETn low SHALL immediately force AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RDATA=0, RRESP=0, both FSMs to idle; READY outputs rise on the first edge after release.
REQ-017 Reset mid-transaction SHALL discard latched address/data; uncommitted writes are lost; RAM contents are not reset and are retained.

Configuration
REQ-018 Macro AXI_SLV_ADDR_CHECK_EN selects address range checking.
REQ-019 Without it: address bits above the RAM index are ignored (aliasing wrap-around); every response is OKAY.
REQ-020 With it: address >= MEM_BYTES SHALL give BRESP/RRESP=2'b10 (SLVERR), no RAM write, RDATA=0; handshake timing unchanged.

Verification
REQ-021 AW=0x10 and W=0xDEADBEEF strobe 4'hF same cycle, BREADY=1; then read 0x10 -> BVALID 1 cycle after accept, BRESP=00, RDATA=0xDEADBEEF, RRESP=00.
REQ-022 W (0x11223344, strobe 4'h5) 3 cycles before AW=0x20 over old 0xAABBCCDD -> BVALID 1 cycle after AW, read 0x20 = 0xAA22CC44.
REQ-023 BREADY low 5 cycles, RREADY low 4 cycles -> BVALID/BRESP and RVALID/RDATA held constant; AWREADY/WREADY/ARREADY stay 0 until response accepted.
REQ-024 Write 0x55 to 0x40 and read 0x40 committing same edge (old 0x0) -> RDATA=0x0; subsequent read = 0x55.
REQ-025 Address 0x1004: with AXI_SLV_ADDR_CHECK_EN -> BRESP/RRESP=10, RDATA=0, 0x004 unchanged; without -> write lands at 0x004, OKAY.
REQ-026 ARESETn low while in W_HAVE_ADDR -> all outputs 0 asynchronously, after release AWREADY=WREADY=1, prior RAM data intact.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite responder over a local byte-lane RAM; independent read and write FSMs.
// Define AXI_SLV_ADDR_CHECK_EN to answer addresses >= MEM_BYTES with SLVERR.
module axi_lite_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                WVALID,
  output logic                WREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                BVALID,
  input  logic                BREADY,
  output logic [1:0]          BRESP,
  input  logic                ARVALID,
  output logic                ARREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  output logic                RVALID,
  input  logic                RREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LANE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(MEM_BYTES) - LANE_BITS;
  localparam int WORDS     = MEM_BYTES / STRB_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXI_SLV_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_VALID} r_state_e;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[LANE_BITS +: IDX_W];
  endfunction

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return CHECK_EN && (64'(a) >= 64'(MEM_BYTES));
  endfunction

  logic [DATA_W-1:0] mem_q [0:WORDS-1];

  w_state_e            w_state_q, w_state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                aw_hs_s, w_hs_s, commit_s, wr_en_s;
  logic [ADDR_W-1:0]   commit_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [STRB_W-1:0]   wr_strb_s;

  r_state_e            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                ar_hs_s;

  // Address bits outside the word index only matter when range checking is on.
  logic unused_addr_s;
  assign unused_addr_s = ^{AWADDR, ARADDR, awaddr_q, commit_addr_s};

  assign aw_hs_s = AWVALID && awready_q;
  assign w_hs_s  = WVALID && wready_q;
  assign ar_hs_s = ARVALID && arready_q;

  // Write channel next state; the RAM commit happens on the edge entering W_RESP.
  always_comb begin
    w_state_d     = w_state_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    commit_s      = 1'b0;
    commit_addr_s = AWADDR;
    wr_data_s     = WDATA;
    wr_strb_s     = WSTRB;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else if (aw_hs_s) begin
          w_state_d = W_HAVE_ADDR;
          awaddr_d  = AWADDR;
        end else if (w_hs_s) begin
          w_state_d = W_HAVE_DATA;
          wdata_d   = WDATA;
          wstrb_d   = WSTRB;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_HAVE_ADDR: begin
        commit_addr_s = awaddr_q;
        if (w_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_d = W_HAVE_ADDR;
        end
      end
      W_HAVE_DATA: begin
        wr_data_s = wdata_q;
        wr_strb_s = wstrb_q;
        if (aw_hs_s) begin
          w_state_d = W_RESP;
          commit_s  = 1'b1;
        end else begin
          w_state_d = W_HAVE_DATA;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_s) begin
      bresp_d = addr_bad(commit_addr_s) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      bresp_d = bresp_q;
    end
    wr_en_s   = commit_s && !addr_bad(commit_addr_s);
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write channel registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // RAM contents survive reset; only strobed lanes are written.
  always_ff @(posedge ACLK) begin
    if (wr_en_s) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb_s[i]) begin
          mem_q[word_idx(commit_addr_s)][8*i +: 8] <= wr_data_s[8*i +: 8];
        end
      end
    end
  end

  // Read channel next state; RAM is sampled before any same-edge write lands.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_VALID;
          if (addr_bad(ARADDR)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = mem_q[word_idx(ARADDR)];
            rresp_d = RESP_OKAY;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_VALID: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_VALID;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_VALID);
  end

  // Read channel registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule
